// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle MIPS datapath (master) and its control FSM (slave).
interface multicycle_control_unit_if #(
  parameter int CNT_WIDTH = 16
);
  logic [5:0]           instr_op;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 pc_write_cond;
  logic                 i_or_d;
  logic                 mem_read;
  logic                 mem_write;
  logic                 ir_write;
  logic                 reg_dst;
  logic                 mem_to_reg;
  logic                 reg_write;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           alu_op;
  logic [1:0]           pc_source;
  logic [3:0]           state;
  logic                 illegal_op;
  logic [CNT_WIDTH-1:0] retired_count;

  modport master (
    output instr_op, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state,
           illegal_op, retired_count
  );

  modport slave (
    input  instr_op, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state,
           illegal_op, retired_count
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: sequences one shared memory port through fetch/decode/
// execute/memory/writeback, flags illegal opcodes and counts retired instructions.
module multicycle_control_unit #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter bit ENABLE_JUMP     = 1'b1,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_unit_if.slave  cu
);
  // state | meaning: FETCH ir load + pc+4 | DECODE branch target | MEM_ADDR/MEM_RD/MEM_WB lw
  // MEM_WR sw | R_EXEC/R_WB r-type | BRANCH beq | JUMP j | ADDI_EXEC/ADDI_WB addi | TRAP halted
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam state_e ILLEGAL_NEXT = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 retire;
  ctrl_t                ctrl, ctrl_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.ir_write  = cu.mem_ready;
        ctrl.pc_write  = cu.mem_ready;
        if (cu.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        case (cu.instr_op)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_J:         state_d = ENABLE_JUMP ? S_JUMP : ILLEGAL_NEXT;
          default:      state_d = ILLEGAL_NEXT;
        endcase
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        state_d = (cu.instr_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (cu.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        if (cu.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = 2'b01;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        ctrl.illegal_op = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase
    cnt_d = cnt_q + CNT_WIDTH'(retire);
  end

  // Reset forces every output low, including the FETCH strobes.
  assign ctrl_o = rst_n ? ctrl : '0;

  assign cu.pc_write      = ctrl_o.pc_write;
  assign cu.pc_write_cond = ctrl_o.pc_write_cond;
  assign cu.i_or_d        = ctrl_o.i_or_d;
  assign cu.mem_read      = ctrl_o.mem_read;
  assign cu.mem_write     = ctrl_o.mem_write;
  assign cu.ir_write      = ctrl_o.ir_write;
  assign cu.reg_dst       = ctrl_o.reg_dst;
  assign cu.mem_to_reg    = ctrl_o.mem_to_reg;
  assign cu.reg_write     = ctrl_o.reg_write;
  assign cu.alu_src_a     = ctrl_o.alu_src_a;
  assign cu.alu_src_b     = ctrl_o.alu_src_b;
  assign cu.alu_op        = ctrl_o.alu_op;
  assign cu.pc_source     = ctrl_o.pc_source;
  assign cu.illegal_op    = ctrl_o.illegal_op;
  assign cu.state         = rst_n ? state_q : 4'd0;
  assign cu.retired_count = rst_n ? cnt_q : '0;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: three parameter variants driven with directed and random
// instruction streams, checked against a per-instruction state-trace model.
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  op_v  [3];
  logic        mr_v  [3];
  logic [16:0] ctrl_v[3];
  logic [3:0]  st_v  [3];
  logic [15:0] cnt_v [3];

  int trap_p[3] = '{1, 0, 1};
  int jump_p[3] = '{1, 1, 0};
  int cw_p  [3] = '{16, 4, 16};
  int exp_cnt[3];

  int n_pass = 0;
  int n_chk  = 0;

  int exp_st[$];
  int exp_mr[$];

  multicycle_control_unit_if #(.CNT_WIDTH(16)) if_a ();
  multicycle_control_unit_if #(.CNT_WIDTH(4))  if_b ();
  multicycle_control_unit_if #(.CNT_WIDTH(16)) if_c ();

  multicycle_control_unit #(.TRAP_ON_ILLEGAL(1'b1), .ENABLE_JUMP(1'b1), .CNT_WIDTH(16))
    dut_a (.clk(clk), .rst_n(rst_n), .cu(if_a));
  multicycle_control_unit #(.TRAP_ON_ILLEGAL(1'b0), .ENABLE_JUMP(1'b1), .CNT_WIDTH(4))
    dut_b (.clk(clk), .rst_n(rst_n), .cu(if_b));
  multicycle_control_unit #(.TRAP_ON_ILLEGAL(1'b1), .ENABLE_JUMP(1'b0), .CNT_WIDTH(16))
    dut_c (.clk(clk), .rst_n(rst_n), .cu(if_c));

  assign if_a.instr_op = op_v[0];
  assign if_a.mem_ready = mr_v[0];
  assign if_b.instr_op = op_v[1];
  assign if_b.mem_ready = mr_v[1];
  assign if_c.instr_op = op_v[2];
  assign if_c.mem_ready = mr_v[2];

  assign ctrl_v[0] = {if_a.pc_write, if_a.pc_write_cond, if_a.i_or_d, if_a.mem_read, if_a.mem_write,
                      if_a.ir_write, if_a.reg_dst, if_a.mem_to_reg, if_a.reg_write, if_a.alu_src_a,
                      if_a.alu_src_b, if_a.alu_op, if_a.pc_source, if_a.illegal_op};
  assign ctrl_v[1] = {if_b.pc_write, if_b.pc_write_cond, if_b.i_or_d, if_b.mem_read, if_b.mem_write,
                      if_b.ir_write, if_b.reg_dst, if_b.mem_to_reg, if_b.reg_write, if_b.alu_src_a,
                      if_b.alu_src_b, if_b.alu_op, if_b.pc_source, if_b.illegal_op};
  assign ctrl_v[2] = {if_c.pc_write, if_c.pc_write_cond, if_c.i_or_d, if_c.mem_read, if_c.mem_write,
                      if_c.ir_write, if_c.reg_dst, if_c.mem_to_reg, if_c.reg_write, if_c.alu_src_a,
                      if_c.alu_src_b, if_c.alu_op, if_c.pc_source, if_c.illegal_op};
  assign st_v[0]  = if_a.state;
  assign st_v[1]  = if_b.state;
  assign st_v[2]  = if_c.state;
  assign cnt_v[0] = if_a.retired_count;
  assign cnt_v[1] = {12'd0, if_b.retired_count};
  assign cnt_v[2] = if_c.retired_count;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  // Control word each state must present, straight from the output table of the control unit.
  function automatic logic [16:0] spec_ctrl(input int st, input logic mr);
    logic pcw, pwc, iord, mrd, mwr, irw, rdst, m2r, rw, srca, ill;
    logic [1:0] srcb, aop, psrc;
    {pcw, pwc, iord, mrd, mwr, irw, rdst, m2r, rw, srca, ill} = '0;
    {srcb, aop, psrc} = '0;
    case (st)
      0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin srca = 1; aop = 2'b10; end
      7:  begin rdst = 1; rw = 1; end
      8:  begin srca = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      9:  begin pcw = 1; psrc = 2'b10; end
      10: begin srca = 1; srcb = 2'b10; end
      11: rw = 1;
      12: ill = 1;
      default: ;
    endcase
    return {pcw, pwc, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, aop, psrc, ill};
  endfunction

  function automatic void push(input int st, input int mr);
    exp_st.push_back(st);
    exp_mr.push_back(mr);
  endfunction

  // Expected state per cycle for one instruction; mr 2 means the bench drives a random don't-care.
  function automatic void build_trace(input int w, input logic [5:0] op, input int sf, input int sm,
                                      output bit retires, output bit traps);
    exp_st.delete();
    exp_mr.delete();
    retires = 1'b1;
    traps   = 1'b0;
    for (int i = 0; i < sf; i++) push(0, 0);
    push(0, 1);
    push(1, 2);
    if (op == 6'b000000) begin
      push(6, 2); push(7, 2);
    end else if (op == 6'b100011) begin
      push(2, 2);
      for (int i = 0; i < sm; i++) push(3, 0);
      push(3, 1); push(4, 2);
    end else if (op == 6'b101011) begin
      push(2, 2);
      for (int i = 0; i < sm; i++) push(5, 0);
      push(5, 1);
    end else if (op == 6'b000100) begin
      push(8, 2);
    end else if (op == 6'b001000) begin
      push(10, 2); push(11, 2);
    end else if (op == 6'b000010 && jump_p[w] == 1) begin
      push(9, 2);
    end else begin
      retires = 1'b0;
      if (trap_p[w] == 1) begin
        traps = 1'b1;
        for (int i = 0; i < 21; i++) push(12, 2);
      end
    end
  endfunction

  task automatic do_reset();
    for (int w = 0; w < 3; w++) mr_v[w] = 1'b1;
    rst_n = 1'b0;
    #1;
    for (int w = 0; w < 3; w++) begin
      chk_val($sformatf("rst_state[%0d]", w), 32'(st_v[w]), 32'd0);
      chk_val($sformatf("rst_ctrl[%0d]", w), 32'(ctrl_v[w]), 32'd0);
      chk_val($sformatf("rst_cnt[%0d]", w), 32'(cnt_v[w]), 32'd0);
      exp_cnt[w] = 0;
    end
    repeat (2) @(negedge clk);
    for (int w = 0; w < 3; w++) mr_v[w] = 1'b0;
    rst_n = 1'b1;
    #1;
    chk_val("rel_ctrl", 32'(ctrl_v[0]), 32'(spec_ctrl(0, 1'b0)));
  endtask

  task automatic run_instr(input int w, input logic [5:0] op, input int sf, input int sm,
                           input int abort_at);
    bit retires, traps;
    int st;
    build_trace(w, op, sf, sm, retires, traps);
    for (int o = 0; o < 3; o++) if (o != w) begin mr_v[o] = 1'b0; op_v[o] = 6'd0; end
    for (int k = 0; k < exp_st.size(); k++) begin
      @(negedge clk);
      st = exp_st[k];
      mr_v[w] = (exp_mr[k] == 2) ? 1'($urandom) : 1'(exp_mr[k]);
      op_v[w] = (st == 0) ? 6'($urandom) : op;
      #1;
      chk_val($sformatf("state[%0d] op=%b cyc%0d", w, op, k), 32'(st_v[w]), 32'(st));
      chk_val($sformatf("ctrl[%0d] st=%0d cyc%0d", w, st, k), 32'(ctrl_v[w]),
              32'(spec_ctrl(st, mr_v[w])));
      if (k == abort_at) begin
        do_reset();
        return;
      end
    end
    if (traps) begin
      do_reset();
      return;
    end
    if (retires) exp_cnt[w] = (exp_cnt[w] + 1) & ((1 << cw_p[w]) - 1);
    @(negedge clk);
    mr_v[w] = 1'b0;
    #1;
    chk_val($sformatf("end_state[%0d] op=%b", w, op), 32'(st_v[w]), 32'd0);
    chk_val($sformatf("retired[%0d] op=%b", w, op), 32'(cnt_v[w]), 32'(exp_cnt[w]));
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] r;
    case ($urandom_range(0, 6))
      0: return 6'b000000;
      1: return 6'b100011;
      2: return 6'b101011;
      3: return 6'b000100;
      4: return 6'b001000;
      5: return 6'b000010;
      default: begin
        r = 6'($urandom);
        while (r == 6'b000000 || r == 6'b100011 || r == 6'b101011 || r == 6'b000100 ||
               r == 6'b001000 || r == 6'b000010) r = 6'($urandom);
        return r;
      end
    endcase
  endfunction

  initial begin
    for (int w = 0; w < 3; w++) begin op_v[w] = 6'd0; mr_v[w] = 1'b0; exp_cnt[w] = 0; end
    do_reset();
    run_instr(0, 6'b000000, 0, 0, -1);
    run_instr(0, 6'b100011, 0, 2, -1);
    run_instr(0, 6'b101011, 3, 0, -1);
    run_instr(0, 6'b111111, 0, 0, -1);
    run_instr(1, 6'b000100, 0, 0, -1);
    run_instr(1, 6'b111111, 1, 0, -1);
    run_instr(2, 6'b000010, 0, 0, -1);
    run_instr(0, 6'b000010, 1, 0, -1);
    for (int i = 0; i < 16; i++) run_instr(1, 6'b000100, $urandom_range(0, 2), 0, -1);
    chk_val("wrap_cnt_b", 32'(cnt_v[1]), 32'd0);
    run_instr(0, 6'b001000, 0, 0, -1);
    run_instr(0, 6'b001000, 1, 0, 3);
    for (int i = 0; i < 150; i++)
      run_instr($urandom_range(0, 2), pick_op(), $urandom_range(0, 3), $urandom_range(0, 3), -1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
